// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the funct3 operation encodings, the control FSM state encoding
// and the fixed iteration count that sets the unit's latency.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/muldiv_if.sv
// Handshake bundle between the execute-stage control and the mul/div unit.
//   start, op, operand_a, operand_b, flush : requester -> unit
//   busy, done, result                     : unit -> requester
// master = requester side (control unit / bench), slave = muldiv_unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath for the mul/div unit.
//   clk      : rising-edge clock
//   load     : capture operand magnitudes and clear the accumulator
//   step     : advance one multiply or divide iteration
//   is_div   : operation class captured on load (1 = divide)
//   a_mag    : multiplicand / dividend magnitude
//   b_mag    : multiplier / divisor magnitude
//   acc_next : value the accumulator takes on the next step; after the
//              final step it is {hi, lo} = product, or {remainder, quotient}
// Multiply: shift-add, multiplier starts in the low half and is consumed
// LSB first while the product grows in from the top.
// Divide: restoring division, dividend shifts out of the low half into a
// 33-bit partial remainder while quotient bits shift in at the bottom.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] acc_next
);

  logic [63:0] acc_p0;
  logic [31:0] opnd_p0;
  logic        is_div_p0;

  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic        rem_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_p0[63:32]} + (acc_p0[0] ? {1'b0, opnd_p0} : 33'd0);
    rem_sh   = acc_p0[63:31];
    rem_diff = rem_sh - {1'b0, opnd_p0};
    rem_ge   = (rem_sh >= {1'b0, opnd_p0});
    if (is_div_p0) begin
      acc_next = {(rem_ge ? rem_diff[31:0] : rem_sh[31:0]), acc_p0[30:0], rem_ge};
    end else begin
      acc_next = {mul_sum, acc_p0[31:1]};
    end
  end

  // ---- stage p0: iteration register ----
  always_ff @(posedge clk) begin
    if (load) begin
      acc_p0    <= {32'd0, (is_div ? a_mag : b_mag)};
      opnd_p0   <= is_div ? b_mag : a_mag;
      is_div_p0 <= is_div;
    end else if (step) begin
      acc_p0    <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the execute-stage ALU.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if slave - start/op/operand_a/operand_b/flush in,
//           busy/done/result out
// A request is accepted from IDLE or from the DONE cycle (back-to-back).
// Operands are latched as unsigned magnitudes plus a result-negate flag;
// the core runs 32 iterations regardless of data, and the final
// sign-corrected value is registered on the last iteration so that done
// and result appear together one cycle later.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  muldiv_if.slave   bus
);

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  op_e             op_q;
  logic            neg_q;
  logic            div_zero_q;
  logic            ovf_q;
  logic [XLEN-1:0] a_raw_q;

  op_e             op_in;
  logic            accept;
  logic            step;
  logic            last_iter;
  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic            neg_in;
  logic            div_zero_in;
  logic            ovf_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [63:0]     acc_next;

  // Sign-correct the unsigned core result and apply the divide special
  // cases, which replace the core value without changing latency.
  function automatic logic [31:0] fix_sign(input op_e op, input logic neg,
                                           input logic dz, input logic ovf,
                                           input logic [31:0] a_raw,
                                           input logic [63:0] acc);
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[31:0] : acc[31:0];
    rem  = neg ? -acc[63:32] : acc[63:32];
    case (op)
      OP_MUL:                     fix_sign = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_sign = prod[63:32];
      OP_DIV, OP_DIVU:            fix_sign = dz ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quo);
      default:                    fix_sign = dz ? a_raw : (ovf ? 32'h0000_0000 : rem);
    endcase
  endfunction

  always_comb begin
    op_in       = op_e'(bus.op);
    accept      = bus.start && !bus.flush && (state_q != S_CALC);
    step        = (state_q == S_CALC) && !bus.flush;
    last_iter   = (cnt_q == 6'(ITER_COUNT - 1));
    a_sgn       = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV)  || (op_in == OP_REM);
    b_sgn       = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg       = a_sgn && bus.operand_a[XLEN-1];
    b_neg       = b_sgn && bus.operand_b[XLEN-1];
    a_mag       = a_neg ? -bus.operand_a : bus.operand_a;
    b_mag       = b_neg ? -bus.operand_b : bus.operand_b;
    // Remainder follows the dividend; everything else follows the XOR.
    neg_in      = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero_in = (bus.operand_b == '0);
    ovf_in      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (bus.operand_a == 32'h8000_0000) && (bus.operand_b == 32'hFFFF_FFFF);
  end

  muldiv_iter_core u_core (
    .clk      (clk),
    .load     (accept),
    .step     (step),
    .is_div   (op_in[2]),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_next (acc_next)
  );

  // ---- stage p0: latched request attributes ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= op_in;
      neg_q      <= neg_in;
      div_zero_q <= div_zero_in;
      ovf_q      <= ovf_in;
      a_raw_q    <= bus.operand_a;
    end
  end

  // ---- control FSM with registered busy/done/result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_CALC: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (last_iter) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= fix_sign(op_q, neg_q, div_zero_q, ovf_q, a_raw_q, acc_next);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Only reachable from IDLE or DONE; overrides the fall-back to IDLE.
      if (accept) begin
        state_q <= S_CALC;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that consumes the two ALU operands selected by the operand muxes (`operand_a` from the ALU-A mux, `operand_b` from the ALU-B mux) and returns a 32-bit result to the writeback path. It sits beside the ALU in the execute stage. It uses a start/busy/done handshake so the control unit stalls the pipeline while the unit computes. It executes all eight M-extension operations with a fixed, data-independent latency.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `op`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  XLEN  rs1 value / multiplicand / dividend.
- `operand_b`  in  XLEN  rs2 value / multiplier / divisor.
- `flush`  in  1  synchronous abort of the operation in flight.
- `busy`  out  1  high while computing.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  final value. Held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1 latches `op`, operand magnitudes, result sign and special-case flags.
  - Clears the 6-bit iteration counter and moves to CALC.
- **CALC**
  - Executes exactly 32 iterations, one per cycle. Multiply uses shift-add into a 64-bit accumulator. Divide uses restoring division with a 33-bit partial remainder.
  - After the 32nd iteration, moves to DONE.
- **DONE**
  - Loads `result` with the sign-corrected value and pulses `done`.
  - Moves to IDLE. If `start`=1 in this cycle, it accepts the new request instead and goes directly to CALC.
- **Sign handling**
  - Signed operands are converted to magnitudes at latch; the unsigned core computes on those.
  - The result is negated at DONE when required.
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU, DIVU, REMU: both unsigned.
  - REM takes the sign of the dividend.
- **Result selection**
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- **Special cases.** These override the core result at DONE but keep the same latency.
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF; REM and REMU return `operand_a`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- **Ignored and abort conditions**
  - `start` while `busy`=1 is ignored; latched operands are unaffected.
  - `flush`=1 in CALC or DONE returns the FSM to IDLE next cycle with no `done` pulse, and `result` unchanged. `flush` has priority over `start`.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, counter 0, `busy`=0, `done`=0, `result`=0x00000000.
- **Latency**
  - `start` sampled at edge E0.
  - `busy` is high from E0 through E32 (32 cycles).
  - `done` is high for exactly one cycle after E32, i.e. 33 cycles after the start edge. `result` is valid in that same cycle.
- **Throughput:** back-to-back operations every 33 cycles (start accepted in the DONE cycle).
- `busy` and `done` are never high together.
- Inputs `op`, `operand_a` and `operand_b` may change freely after E0.
- Reset asserted mid-operation aborts immediately to reset values; there is no `done` pulse after reset release.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings `OP_MUL` … `OP_REMU`;
  - state encoding `S_IDLE`, `S_CALC`, `S_DONE`;
  - `ITER_COUNT` = 32.
- One natural sub-module, `muldiv_iter_core`:
  - unsigned datapath, 64-bit accumulator, one multiply or divide step per enable;
  - control FSM, sign handling and special-case logic stay in `muldiv_unit`.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD → `result`=0xFFFFFFEB. `done` exactly 33 cycles after start; `busy` high 32 cycles before it.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same operands → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 0x00000002 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU same → 0x7FFFFFFC. REMU same → 0x00000001.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0x00000000; latency still 33.
- Start DIVU 100/7, pulse `start` again at cycle 5 with other operands, then issue a second op in the DONE cycle:
  - first result = 0x0000000E;
  - second op's `done` arrives 33 cycles later.
- `flush` at cycle 10 of an operation → `busy`=0 next cycle, no `done`, `result` keeps the prior value.
- `rst_n` low at cycle 20 → all outputs 0 immediately; no `done` after release.
